// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Shares one SRAM-like master bus (req/addr_ok/data_ok) between the CPU
// instruction port and the CPU data port. Data requests normally win. An
// instruction request that keeps losing is forced through after STARVE_LIMIT
// losses. The owner of every accepted request is queued in an in-order ID FIFO,
// and each master response is steered back to that owner with no added latency.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_* / data_*              slave side: req, wr, size, addr, wdata in;
//                                addr_ok, data_ok, rdata out
//   m_req, m_wr, m_size,         master request and muxed request fields
//   m_addr, m_wdata
//   m_addr_ok, m_data_ok,        master accept, in-order response, read data
//   m_rdata
//   busy                         at least one transaction outstanding
//   proto_err                    sticky: master responded with nothing outstanding
module sram_like_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] id_mem;       // 0 = inst owns the slot, 1 = data
    logic [SW-1:0]    starve_cnt;
    logic             busy_q;
    logic             proto_err_q;

    logic can_issue;
    logic starved;
    logic sel_inst;
    logic sel_data;
    logic push;
    logic pop;
    logic fifo_empty;
    logic head_id;

    // can_issue looks only at the registered count, so a pop in the same
    // cycle never frees a slot for a push while the FIFO is full.
    assign fifo_empty = (count == '0);
    assign can_issue  = (count < DEPTH_C);
    assign starved    = (starve_cnt >= LIMIT_C);

    assign sel_inst = inst_req & (~data_req | starved);
    assign sel_data = data_req & ~sel_inst;

    // resetn gates the request so nothing reaches the master while in reset.
    assign m_req   = resetn & can_issue & (sel_inst | sel_data);
    assign m_wr    = sel_inst ? inst_wr    : data_wr;
    assign m_size  = sel_inst ? inst_size  : data_size;
    assign m_addr  = sel_inst ? inst_addr  : data_addr;
    assign m_wdata = sel_inst ? inst_wdata : data_wdata;

    assign inst_addr_ok = m_addr_ok & m_req & sel_inst;
    assign data_addr_ok = m_addr_ok & m_req & sel_data;

    assign push    = m_req & m_addr_ok;
    assign pop     = resetn & m_data_ok & ~fifo_empty;
    assign head_id = id_mem[rd_ptr];

    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign busy      = busy_q;
    assign proto_err = proto_err_q;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            id_mem      <= '0;
            starve_cnt  <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            count  <= count_nxt;
            busy_q <= (count_nxt != '0);
            if (push) begin
                id_mem[wr_ptr] <= sel_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (m_data_ok && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
            // Any cycle an inst request goes unaccepted is a loss, whether it
            // lost to data or the master/FIFO stalled; saturate at the limit.
            if (inst_req && !inst_addr_ok) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like master bus between the CPU instruction port and the CPU data port.
- The master bus is the single-port request/addr_ok/data_ok protocol that feeds the AXI bridge or a unified SRAM.
- Arbitrates requests with data-first priority plus an anti-starvation override.
- Records the owner of every accepted request in an in-order ID FIFO and routes each data_ok/rdata response back to that owner.

Parameters:
- DEPTH, 4, maximum outstanding accepted-but-unanswered transactions; power of 2, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles an inst request may lose before it is forced to win; minimum 1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_req / data_req  in  1  slave request
- inst_wr / data_wr  in  1  write enable
- inst_size / data_size  in  2  00 byte, 01 half, 10 word
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this slave
- inst_rdata / data_rdata  out  32  read data
- m_req  out  1  master request
- m_wr  out  1  master write enable
- m_size  out  2  master transfer size
- m_addr  out  32  master address
- m_wdata  out  32  master write data
- m_addr_ok  in  1  master accepts request
- m_data_ok  in  1  master response, returned in order
- m_rdata  in  32  master read data
- busy  out  1  outstanding count nonzero
- proto_err  out  1  sticky flag: m_data_ok seen while FIFO empty

Behaviour:
- Reset is asynchronous and active-low, on one clock clk. While resetn=0:
  - count=0, FIFO pointers=0, starve counter=0, proto_err=0.
  - busy, m_req, all addr_ok and all data_ok are 0.
- Grant is combinational and evaluated each cycle:
  - can_issue = (count < DEPTH).
  - sel_inst = inst_req & (~data_req | starve_cnt >= STARVE_LIMIT).
  - sel_data = data_req & ~sel_inst.
- Master request:
  - m_req = can_issue & (sel_inst | sel_data).
  - m_wr, m_size, m_addr and m_wdata are muxed from the selected slave.
  - When nothing is selected they are driven from the data slave.
- Accept:
  - inst_addr_ok = m_addr_ok & m_req & sel_inst.
  - data_addr_ok = m_addr_ok & m_req & sel_data.
  - At most one is high per cycle.
- Push: on accept (m_req & m_addr_ok), write the owner ID (0 = inst, 1 = data) at the write pointer, advance it mod DEPTH, and increment count.
- Pop:
  - On m_data_ok with count > 0, read the ID at the read pointer, advance it mod DEPTH, and decrement count.
  - inst_data_ok = m_data_ok & count>0 & id==0; data_data_ok likewise for id==1.
  - Both rdata outputs carry m_rdata unconditionally. Response latency through the block is zero cycles (combinational).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - When count == DEPTH, no push is possible even if a pop occurs that cycle (can_issue uses the registered count).
- m_data_ok with count == 0: ignored (no pointer or count change, no slave data_ok) and proto_err is set to 1 until reset.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) in each cycle with inst_req & ~inst_addr_ok.
  - Clears to 0 on inst_addr_ok or when inst_req=0.
  - A stall from m_addr_ok=0 or FIFO full also counts as a loss.
- A grant is not locked across cycles: if m_addr_ok=0, selection is re-evaluated next cycle. Slaves hold their request until addr_ok, per protocol.
- busy = (count != 0), registered.
- count is $clog2(DEPTH)+1 bits wide; pointers are $clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Single inst read, then single data read, m_addr_ok=1, m_data_ok one cycle later with m_rdata=0xDEADBEEF each:
  - inst_addr_ok then data_addr_ok.
  - inst_data_ok then data_data_ok, each with rdata 0xDEADBEEF.
  - Back to idle: busy=0.
- Both slaves request continuously, m_addr_ok=1, responses every cycle:
  - data wins 8 consecutive cycles, then inst wins in cycle 9.
  - Starve counter clears and the pattern repeats.
- Master holds m_data_ok=0 while slaves issue 5 requests:
  - exactly 4 accepted, m_req=0 in the 5th cycle, busy=1.
  - After one m_data_ok, m_req reasserts in the following cycle.
- Interleaved accepts inst, data, data, inst, then 4 responses with rdata 1, 2, 3, 4:
  - inst_data_ok(1), data_data_ok(2), data_data_ok(3), inst_data_ok(4).
- Pulse m_data_ok with count=0:
  - no slave data_ok, proto_err=1 and stays 1.
  - Assert resetn=0 asynchronously mid-transaction: proto_err, busy and m_req drop to 0 immediately, without waiting for a clock edge.
- Push and pop in the same cycle at count=2, with data_wdata=0x12345678 and data_size=01:
  - count stays 2.
  - m_wdata=0x12345678, m_size=01.
  - Pointers wrap correctly after 8 further transactions.
